// File: rtl/neuron_param_loader_if.sv
// Parameter stream channel into the neuron weight/bias loader.
// Valid/ready: a beat transfers on a rising clk edge where s_valid & s_ready; s_data is don't-care otherwise.
interface neuron_param_loader_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/neuron_param_loader.sv
// Sequences a 32-bit parameter stream into per-neuron weight and bias write strobes
// broadcast to a layer's neuron array; one start command loads one complete layer.
module neuron_param_loader #(
   parameter int maxNeurons = 32,
   parameter int maxWeights = 1024,
   parameter int neuronBase = 0,
   localparam int NW = $clog2(maxNeurons + 1),
   localparam int WW = $clog2(maxWeights + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [31:0]                 layer_num,
   input  logic [NW-1:0]               num_neurons,
   input  logic [WW-1:0]               num_weights,
   neuron_param_loader_if.slave        stream,
   output logic                        weightValid,
   output logic [31:0]                 weightValue,
   output logic                        biasValid,
   output logic [31:0]                 biasValue,
   output logic [31:0]                 config_layer_num,
   output logic [31:0]                 config_neuron_num,
   output logic                        busy,
   output logic                        done,
   output logic                        cfg_err,
   output logic [1:0]                  state_dbg
);

   typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, DONE} state_t;

   state_t          state, state_nxt;
   logic [31:0]     layer_q;
   logic [NW-1:0]   nn_q, neuron_cnt;
   logic [WW-1:0]   nw_q, weight_cnt;
   logic            cmd_ok;
   logic            last_weight, last_neuron;

   assign cmd_ok      = (num_neurons != '0) && (num_weights != '0);
   assign last_weight = (weight_cnt == nw_q - WW'(1));
   assign last_neuron = (neuron_cnt == nn_q - NW'(1));
   assign state_dbg   = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // s_ready depends only on state, so next-state may use s_valid alone as the accept.
   always_comb begin
      state_nxt      = state;
      stream.s_ready = 1'b0;
      busy           = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && cmd_ok) state_nxt = WEIGHT;
         end
         WEIGHT: begin
            stream.s_ready = 1'b1;
            if (stream.s_valid && last_weight) state_nxt = BIAS;
         end
         BIAS: begin
            stream.s_ready = 1'b1;
            if (stream.s_valid) state_nxt = last_neuron ? DONE : WEIGHT;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         layer_q    <= '0;
         nn_q       <= '0;
         nw_q       <= '0;
         weight_cnt <= '0;
         neuron_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (start && cmd_ok) begin
               layer_q    <= layer_num;
               nn_q       <= num_neurons;
               nw_q       <= num_weights;
               weight_cnt <= '0;
               neuron_cnt <= '0;
            end
            WEIGHT: if (stream.s_valid) weight_cnt <= weight_cnt + WW'(1);
            BIAS: if (stream.s_valid) begin
               weight_cnt <= '0;
               if (!last_neuron) neuron_cnt <= neuron_cnt + NW'(1);
            end
            default: ;
         endcase
      end
   end

   // Values and config fields only move with a strobe, so they hold between writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         weightValid       <= 1'b0;
         weightValue       <= '0;
         biasValid         <= 1'b0;
         biasValue         <= '0;
         config_layer_num  <= '0;
         config_neuron_num <= '0;
         done              <= 1'b0;
         cfg_err           <= 1'b0;
      end else begin
         weightValid <= 1'b0;
         biasValid   <= 1'b0;
         done        <= (state == DONE);
         cfg_err     <= (state == IDLE) && start && !cmd_ok;
         if (state == WEIGHT && stream.s_valid) begin
            weightValid       <= 1'b1;
            weightValue       <= stream.s_data;
            config_layer_num  <= layer_q;
            config_neuron_num <= 32'(neuronBase) + 32'(neuron_cnt);
         end
         if (state == BIAS && stream.s_valid) begin
            biasValid         <= 1'b1;
            biasValue         <= stream.s_data;
            config_layer_num  <= layer_q;
            config_neuron_num <= 32'(neuronBase) + 32'(neuron_cnt);
         end
      end
   end

endmodule

// File: tb/tb_neuron_param_loader.sv
// Bench for neuron_param_loader: directed loads checked every cycle against a
// beat-list model of the expected strobe sequence, plus literal spot checks.
module tb_neuron_param_loader;
   localparam int MAX_N = 32;
   localparam int MAX_W = 1024;
   localparam int BASE  = 0;
   localparam int NW = $clog2(MAX_N + 1);
   localparam int WW = $clog2(MAX_W + 1);
   localparam int P_IDLE = 0, P_LOAD = 1, P_DONE = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   layer_num = '0;
   logic [NW-1:0] num_neurons = '0;
   logic [WW-1:0] num_weights = '0;
   logic          weightValid, biasValid, busy, done, cfg_err;
   logic [31:0]   weightValue, biasValue, config_layer_num, config_neuron_num;
   logic [1:0]    state_dbg;

   neuron_param_loader_if sif ();

   neuron_param_loader #(.maxNeurons(MAX_N), .maxWeights(MAX_W), .neuronBase(BASE)) dut (
      .clk(clk), .rst(rst), .start(start), .layer_num(layer_num),
      .num_neurons(num_neurons), .num_weights(num_weights), .stream(sif.slave),
      .weightValid(weightValid), .weightValue(weightValue),
      .biasValid(biasValid), .biasValue(biasValue),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .busy(busy), .done(done), .cfg_err(cfg_err), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] seed, input int idx);
      return seed + 32'(idx);
   endfunction

   // model: the whole load is a list of beats {is_bias, layer, neuron, value}
   logic [96:0] exp_q[$];
   logic [31:0] cur_seed = '0;
   int          phase = P_IDLE;
   logic        e_ready = 0, e_busy = 0, e_wv = 0, e_bv = 0, e_done = 0, e_err = 0;
   logic [31:0] e_wval = '0, e_bval = '0, e_layer = '0, e_neur = '0;

   always @(posedge clk or negedge rst) begin
      logic [96:0] it;
      if (!rst) begin
         phase = P_IDLE;
         exp_q.delete();
         {e_ready, e_busy, e_wv, e_bv, e_done, e_err} = '0;
         {e_wval, e_bval, e_layer, e_neur} = '0;
      end else begin
         {e_wv, e_bv, e_done, e_err} = '0;
         case (phase)
            P_IDLE: if (start) begin
               if (num_neurons == 0 || num_weights == 0) e_err = 1'b1;
               else begin
                  for (int n = 0; n < int'(num_neurons); n++)
                     for (int k = 0; k <= int'(num_weights); k++)
                        exp_q.push_back({k == int'(num_weights), layer_num, 32'(BASE + n),
                                         word(cur_seed, n * (int'(num_weights) + 1) + k)});
                  phase = P_LOAD;
               end
            end
            P_LOAD: if (sif.s_valid) begin
               it = exp_q.pop_front();
               if (it[96]) begin e_bv = 1'b1; e_bval = it[31:0]; end
               else        begin e_wv = 1'b1; e_wval = it[31:0]; end
               e_layer = it[95:64];
               e_neur  = it[63:32];
               if (exp_q.size() == 0) phase = P_DONE;
            end
            default: begin e_done = 1'b1; phase = P_IDLE; end
         endcase
         e_ready = (phase == P_LOAD);
         e_busy  = (phase != P_IDLE);
      end
   end

   // observation log for literal checks
   logic [31:0] obs_val[$], obs_neur[$], obs_layer[$];
   logic        obs_bias[$];
   int          obs_cyc[$];
   int          err_cnt = 0, done_cyc = -1;
   logic        done_seen = 0, busy_seen = 0, ready_seen = 0;

   task automatic clear_log();
      obs_val.delete(); obs_neur.delete(); obs_layer.delete(); obs_bias.delete(); obs_cyc.delete();
      err_cnt = 0; done_cyc = -1; done_seen = 0; busy_seen = 0; ready_seen = 0;
   endtask

   // compare process
   always @(negedge clk) begin
      chk("s_ready", 32'(sif.s_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("weightValid", 32'(weightValid), 32'(e_wv));
      chk("biasValid", 32'(biasValid), 32'(e_bv));
      chk("weightValue", weightValue, e_wval);
      chk("biasValue", biasValue, e_bval);
      chk("config_layer_num", config_layer_num, e_layer);
      chk("config_neuron_num", config_neuron_num, e_neur);
      chk("done", 32'(done), 32'(e_done));
      chk("cfg_err", 32'(cfg_err), 32'(e_err));
      if (weightValid || biasValid) begin
         obs_val.push_back(biasValid ? biasValue : weightValue);
         obs_bias.push_back(biasValid);
         obs_neur.push_back(config_neuron_num);
         obs_layer.push_back(config_layer_num);
         obs_cyc.push_back(cyc);
      end
      if (done) begin done_seen = 1'b1; done_cyc = cyc; end
      if (cfg_err) err_cnt++;
      busy_seen  = busy_seen | busy;
      ready_seen = ready_seen | sif.s_ready;
   end

   // driver tasks
   task automatic do_start(input logic [31:0] layer, input int nn, input int nw);
      @(posedge clk); #1;
      layer_num = layer; num_neurons = NW'(nn); num_weights = WW'(nw); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_load(input logic [31:0] layer, input int nn, input int nw,
                           input logic [31:0] seed, input bit stall,
                           input int inject_at, input int abort_after);
      int   idx = 0;
      int   budget = 60000;
      bit   tog = 1'b1;
      bit   acc;
      bit   injected = 1'b0;
      clear_log();
      cur_seed = seed;
      do_start(layer, nn, nw);
      while (idx < nn * (nw + 1) && budget > 0) begin
         sif.s_valid = stall ? tog : 1'b1;
         tog = ~tog;
         sif.s_data = sif.s_valid ? word(seed, idx) : $urandom;
         if (idx == inject_at && !injected) begin
            start = 1'b1; layer_num = 32'd5; injected = 1'b1;
         end else start = 1'b0;
         @(negedge clk);
         acc = sif.s_valid && sif.s_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         budget--;
         if (abort_after > 0 && idx == abort_after) break;
      end
      sif.s_valid = 1'b0;
      start = 1'b0;
      if (budget == 0) chk("beat_timeout", 32'(idx), 32'(nn * (nw + 1)));
      if (abort_after == 0) begin
         for (int i = 0; i < 10 && !done_seen; i++) @(posedge clk);
         #1;
         chk("done_seen", 32'(done_seen), 32'd1);
      end
   endtask

   initial begin
      #5_000_000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 32'(sif.s_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_neuron", config_neuron_num, 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // basic load
      run_load(32'd2, 2, 3, 32'd1, 1'b0, -1, 0);
      chk("basic_count", 32'(obs_val.size()), 32'd8);
      if (obs_val.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("basic_val", obs_val[i], 32'(i + 1));
            chk("basic_bias", 32'(obs_bias[i]), 32'(i == 3 || i == 7));
            chk("basic_neur", obs_neur[i], 32'(i / 4));
            chk("basic_layer", obs_layer[i], 32'd2);
         end
         chk("basic_span", 32'(obs_cyc[7] - obs_cyc[0]), 32'd7);
         chk("basic_done_lat", 32'(done_cyc - obs_cyc[7]), 32'd1);
      end
      repeat (3) @(posedge clk);

      // stalls: valid 1,0,1,0...
      run_load(32'd2, 2, 3, 32'd1, 1'b1, -1, 0);
      chk("stall_count", 32'(obs_val.size()), 32'd8);
      if (obs_val.size() == 8) begin
         chk("stall_span", 32'(obs_cyc[7] - obs_cyc[0]), 32'd14);
         chk("stall_bias8", obs_val[7], 32'd8);
         chk("stall_neur8", obs_neur[7], 32'd1);
      end
      repeat (3) @(posedge clk);

      // invalid command
      clear_log();
      do_start(32'd7, 2, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("inv_err_cnt", 32'(err_cnt), 32'd1);
      chk("inv_busy_seen", 32'(busy_seen), 32'd0);
      chk("inv_ready_seen", 32'(ready_seen), 32'd0);
      chk("inv_strobes", 32'(obs_val.size()), 32'd0);

      // second start mid-stream is ignored
      run_load(32'd2, 2, 3, 32'h100, 1'b0, 3, 0);
      chk("mid_err_cnt", 32'(err_cnt), 32'd0);
      chk("mid_count", 32'(obs_val.size()), 32'd8);
      if (obs_val.size() == 8) chk("mid_layer_last", obs_layer[7], 32'd2);
      repeat (3) @(posedge clk);

      // reset mid-load after 4 weight accepts
      run_load(32'd3, 2, 5, 32'h200, 1'b0, -1, 4);
      rst = 1'b0;
      #1;
      chk("abort_wv", 32'(weightValid), 32'd0);
      chk("abort_wval", weightValue, 32'd0);
      chk("abort_layer", config_layer_num, 32'd0);
      chk("abort_neur", config_neuron_num, 32'd0);
      chk("abort_ready", 32'(sif.s_ready), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      @(posedge clk); #3;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      run_load(32'd9, 1, 2, 32'h300, 1'b0, -1, 0);
      chk("fresh_count", 32'(obs_val.size()), 32'd3);
      if (obs_val.size() == 3) begin
         chk("fresh_neur", obs_neur[2], 32'd0);
         chk("fresh_bias", obs_val[2], 32'h302);
      end
      repeat (3) @(posedge clk);

      // max size
      run_load(32'd11, MAX_N, MAX_W, 32'h1000_0000, 1'b0, -1, 0);
      chk("max_count", 32'(obs_val.size()), 32'(MAX_N * (MAX_W + 1)));
      if (obs_val.size() > 0) begin
         chk("max_last_neur", obs_neur[obs_val.size() - 1], 32'(BASE + MAX_N - 1));
         chk("max_last_bias", 32'(obs_bias[obs_val.size() - 1]), 32'd1);
      end
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
